// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: receiver state encoding and the
// default oversampling / frame-width constants also used by the baud
// generator.
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;  // enable ticks per bit period
  localparam int UART_DATA_BITS  = 8;   // data bits per frame, LSB first

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// ----------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer for a single asynchronous input. Both flops reset to
// RESET_VAL so the synchronized output starts in the line's idle level.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   i_async  in   asynchronous input
//   o_sync   out  input re-timed to clk (2 cycles latency)
// ----------------------------------------------------------------------------
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments make the two flops a true pipeline;
      // blocking ones would collapse them into a single stage.
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule : uart_sync

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver driven by an oversampling enable tick. Each bit is
// sampled in its middle; completed bytes are reported with sticky flags that
// stay set until software acknowledges with clr_rda.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   enable     in   oversample tick (OVERSAMPLE per bit period)
//   rxd        in   raw serial line, idle high, asynchronous to clk
//   clr_rda    in   acknowledge: clears rda, frame_err and overrun
//   rx_data    out  last good received byte
//   rda        out  receive data available (sticky)
//   frame_err  out  stop bit sampled low (sticky)
//   overrun    out  byte completed while rda was already set (sticky)
//   busy       out  receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rxd,
  input  logic                 clr_rda,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 w_rxd_s;
  rx_state_t            r_state;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rda;
  logic                 r_frame_err;
  logic                 r_overrun;

  uart_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rxd),
    .o_sync  (w_rxd_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rda       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // Acknowledge first; a byte completing on the same edge assigns the
      // flags again below and therefore takes precedence.
      if (clr_rda) begin
        r_rda       <= 1'b0;
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
      end

      if (enable) begin
        case (r_state)
          IDLE: begin
            if (!w_rxd_s) begin
              r_state    <= START;
              r_tick_cnt <= '0;
            end
          end

          START: begin
            if (r_tick_cnt == HALF_LAST) begin
              // Mid start bit: a line that is high again was only a glitch.
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_state    <= w_rxd_s ? IDLE : DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end

          DATA: begin
            if (r_tick_cnt == FULL_LAST) begin
              r_shift    <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
              r_tick_cnt <= '0;
              r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
              if (r_bit_cnt == BIT_LAST) begin
                r_state <= STOP;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end

          STOP: begin
            if (r_tick_cnt == FULL_LAST) begin
              // Sampling mid stop bit lets the next start edge be caught
              // immediately for back-to-back frames.
              r_tick_cnt <= '0;
              r_state    <= IDLE;
              if (w_rxd_s) begin
                r_rx_data   <= r_shift;
                r_rda       <= 1'b1;
                r_frame_err <= clr_rda ? 1'b0 : r_frame_err;
                r_overrun   <= clr_rda ? 1'b0 : (r_overrun | r_rda);
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rda       = r_rda;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule : uart_rx

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART: it consumes the oversampling `enable` tick produced by the baud-rate generator and deserializes 8N1 frames from the asynchronous `rxd` line. It sits between the board RX pin and the bus interface/SPART register logic. It reports each completed byte with a sticky data-available flag, plus framing and overrun error flags, until software acknowledges.

## Interface
- `OVERSAMPLE`, 16: `enable` ticks per bit period; must be even and ≥4.
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `enable`  input  1  single-cycle oversample tick from the baud generator (OVERSAMPLE per bit).
- `rxd`  input  1  raw serial line; idle high; asynchronous to `clk`.
- `clr_rda`  input  1  single-cycle acknowledge; clears `rda`, `frame_err` and `overrun`.
- `rx_data`  output  DATA_BITS  last good received byte.
- `rda`  output  1  receive data available (sticky).
- `frame_err`  output  1  stop bit sampled low (sticky).
- `overrun`  output  1  a new byte completed while `rda` was already set (sticky).
- `busy`  output  1  high in any state other than IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer. Both flops reset to 1. All sampling uses the synchronized value `rxd_s`.
- The state machine is IDLE, START, DATA, STOP. It advances only on cycles where `enable` = 1. `tick_cnt` has width $clog2(OVERSAMPLE) and `bit_cnt` has width $clog2(DATA_BITS+1).
- **IDLE:** on an `enable` tick with `rxd_s` = 0, go to START with `tick_cnt` = 0.
- **START:** increment `tick_cnt` each tick. When `tick_cnt` = OVERSAMPLE/2−1 (mid start bit):
  - if `rxd_s` = 0, go to DATA with `tick_cnt` = 0 and `bit_cnt` = 0;
  - otherwise the start was false; return to IDLE with no flag change.
- **DATA:** when `tick_cnt` = OVERSAMPLE−1, sample `rxd_s` into the shift register MSB and shift right (LSB first), set `tick_cnt` = 0, and increment `bit_cnt`. After the sample that makes `bit_cnt` = DATA_BITS, go to STOP.
- **STOP:** when `tick_cnt` = OVERSAMPLE−1, sample `rxd_s` and go to IDLE. This happens mid stop bit, which allows immediate back-to-back frames.
  - If the stop bit is 1: load `rx_data` from the shift register and set `rda`. If `rda` was already 1 and `clr_rda` is not asserted this cycle, also set `overrun`. The new byte overwrites the old one.
  - If the stop bit is 0: set `frame_err`. `rx_data` and `rda` are unchanged.
- **`clr_rda`:** clears all three flags on the next edge. If `clr_rda` coincides with a byte completion, the completion wins: `rda` = 1, `overrun` = 0, and `frame_err` takes this frame's result.
- `clr_rda` has no effect on the state machine.
- **Reset:** valid at any time, including mid-frame. It forces IDLE, counters to 0, shift register to 0, `rx_data` = 0, `rda` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0, and synchronizer flops to 1.

## Timing
- There are 2 clk cycles of synchronizer latency from an `rxd` edge to `rxd_s`.
- Let tick 0 be the first `enable` tick that sees `rxd_s` = 0. Then:
  - the start check is at tick OVERSAMPLE/2;
  - data bit k (0-based) is sampled at tick OVERSAMPLE/2 + (k+1)·OVERSAMPLE;
  - the stop bit is sampled at tick OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE.
  - With the defaults these are ticks 8, 24…136, and 152.
- `rda`, `rx_data`, `frame_err` and `overrun` update on the same edge as the stop sample, so they are visible the cycle after that `enable` tick.
- `busy` rises the edge after tick 0 and falls on the stop-sample edge.
- `enable` held high continuously is legal: the block treats every cycle as a tick.

## Structure
- Shared package `uart_pkg` holds:
  - `rx_state_t` enum (IDLE, START, DATA, STOP);
  - default constants `UART_OVERSAMPLE` = 16 and `UART_DATA_BITS` = 8, which the baud generator also uses.
- One sub-module, `uart_sync`: a 2-flop synchronizer with a reset value parameter (1 here). It is reused for other async inputs.
- The state machine, counters, shift register and flags stay in `uart_rx`.

## Test plan
- **Reset then idle:** `rxd` = 1 and `enable` every 4 clocks for 500 ticks → `rda` = 0, `busy` = 0, `rx_data` = 0x00 throughout.
- **Single frame:** send 0xA5 (8N1, 16 ticks/bit) → `rda` rises on the stop-sample edge (tick 152), `rx_data` = 0xA5, `frame_err` = 0. Then pulse `clr_rda` → `rda` = 0 on the next edge.
- **Glitch rejection:** drive `rxd` low for 5 ticks, then high → START aborts at tick 8, the block returns to IDLE, and no flag changes.
- **Framing error:** send 0x3C with the stop bit = 0 → `frame_err` = 1, `rda` stays 0, `rx_data` keeps its prior value.
- **Overrun and simultaneous ack:**
  - Send 0x11 then 0x22 back-to-back without clearing → `rx_data` = 0x22, `rda` = 1, `overrun` = 1.
  - Repeat, with `clr_rda` pulsed on the exact edge of the second stop sample → `rda` = 1, `overrun` = 0.
- **Reset mid-frame:** assert `rst` low during data bit 4 of 0xFF, release it, then send 0x5A → clean reception of 0x5A with no stale bits and no error flags.
